// File: rtl/axi_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module   : axi_arbiter2
//  Purpose  : Two-master to one-slave AXI arbiter. Master 1 (instruction
//             fetch) is read-only; master 2 (load/store bus port) reads and
//             writes. Reads are arbitrated round-robin by a three-state FSM,
//             writes pass through a four-state FSM that only master 2 uses.
//             The two FSMs are fully independent.
//  Ports    : clk, rst (asynchronous, active-high)
//             M1  : AR in / arready1 out, R out / rready1 in
//             M2  : AR, AW, W in / arready2, awready2, wready2 out,
//                   R, B out / rready2, bready2 in
//             Slave side : AR, AW, W out / R, B in, matching readies
//             rd_busy    : read FSM not idle
//             burst_err  : sticky, rlast_s seen on a beat other than arlen
//  Revision : 1.0  initial release
// ============================================================================
module axi_arbiter2 #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  // Master 1 read address / data
  input  logic [ADDR_WIDTH-1:0]     araddr1,
  input  logic [1:0]                arburst1,
  input  logic [7:0]                arlen1,
  input  logic [2:0]                arsize1,
  input  logic                      arvalid1,
  output logic                      arready1,
  output logic [DATA_WIDTH-1:0]     rdata1,
  output logic [1:0]                rresp1,
  output logic                      rlast1,
  output logic                      rvalid1,
  input  logic                      rready1,
  // Master 2 read address / data
  input  logic [ADDR_WIDTH-1:0]     araddr2,
  input  logic [1:0]                arburst2,
  input  logic [7:0]                arlen2,
  input  logic [2:0]                arsize2,
  input  logic                      arvalid2,
  output logic                      arready2,
  output logic [DATA_WIDTH-1:0]     rdata2,
  output logic [1:0]                rresp2,
  output logic                      rlast2,
  output logic                      rvalid2,
  input  logic                      rready2,
  // Master 2 write address / data / response
  input  logic [ADDR_WIDTH-1:0]     awaddr2,
  input  logic [1:0]                awburst2,
  input  logic [7:0]                awlen2,
  input  logic                      awvalid2,
  output logic                      awready2,
  input  logic [DATA_WIDTH-1:0]     wdata2,
  input  logic [DATA_WIDTH/8-1:0]   wstrb2,
  input  logic                      wlast2,
  input  logic                      wvalid2,
  output logic                      wready2,
  output logic [1:0]                bresp2,
  output logic                      bvalid2,
  input  logic                      bready2,
  // Slave read address / data
  output logic [ADDR_WIDTH-1:0]     araddr_s,
  output logic [1:0]                arburst_s,
  output logic [7:0]                arlen_s,
  output logic [2:0]                arsize_s,
  output logic                      arvalid_s,
  input  logic                      arready_s,
  input  logic [DATA_WIDTH-1:0]     rdata_s,
  input  logic [1:0]                rresp_s,
  input  logic                      rlast_s,
  input  logic                      rvalid_s,
  output logic                      rready_s,
  // Slave write address / data / response
  output logic [ADDR_WIDTH-1:0]     awaddr_s,
  output logic [1:0]                awburst_s,
  output logic [7:0]                awlen_s,
  output logic                      awvalid_s,
  input  logic                      awready_s,
  output logic [DATA_WIDTH-1:0]     wdata_s,
  output logic [DATA_WIDTH/8-1:0]   wstrb_s,
  output logic                      wlast_s,
  output logic                      wvalid_s,
  input  logic                      wready_s,
  input  logic [1:0]                bresp_s,
  input  logic                      bvalid_s,
  output logic                      bready_s,
  // Status
  output logic                      rd_busy,
  output logic                      burst_err
);

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_AR   = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } wr_state_e;

  localparam logic GNT_M1 = 1'b0;
  localparam logic GNT_M2 = 1'b1;

  rd_state_e  rd_state_q, rd_state_d;
  logic       gnt_q, gnt_d;
  logic       last_gnt_q, last_gnt_d;
  logic [7:0] arlen_q, arlen_d;
  logic [7:0] beat_cnt_q, beat_cnt_d;
  logic       burst_err_q, burst_err_d;
  wr_state_e  wr_state_q, wr_state_d;

  logic gnt_arvalid;
  logic gnt_rready;
  logic r_hs;

  assign gnt_arvalid = (gnt_q == GNT_M1) ? arvalid1 : arvalid2;
  assign gnt_rready  = (gnt_q == GNT_M1) ? rready1  : rready2;
  assign r_hs        = (rd_state_q == R_DATA) && rvalid_s && gnt_rready;

  // --------------------------------------------------------------------------
  // Read FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_q  <= R_IDLE;
      gnt_q       <= GNT_M2;
      last_gnt_q  <= GNT_M1;
      arlen_q     <= 8'd0;
      beat_cnt_q  <= 8'd0;
      burst_err_q <= 1'b0;
    end else begin
      rd_state_q  <= rd_state_d;
      gnt_q       <= gnt_d;
      last_gnt_q  <= last_gnt_d;
      arlen_q     <= arlen_d;
      beat_cnt_q  <= beat_cnt_d;
      burst_err_q <= burst_err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Read FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    rd_state_d  = rd_state_q;
    gnt_d       = gnt_q;
    last_gnt_d  = last_gnt_q;
    arlen_d     = arlen_q;
    beat_cnt_d  = beat_cnt_q;
    burst_err_d = burst_err_q;
    case (rd_state_q)
      R_IDLE: begin
        if (arvalid1 || arvalid2) begin
          // Contention goes to whichever master was not served last.
          if (arvalid1 && arvalid2) begin
            gnt_d = ~last_gnt_q;
          end else begin
            gnt_d = arvalid1 ? GNT_M1 : GNT_M2;
          end
          rd_state_d = R_AR;
        end
      end
      R_AR: begin
        if (!gnt_arvalid) begin
          // Granted master withdrew its request: re-arbitrate.
          rd_state_d = R_IDLE;
        end else if (arready_s) begin
          arlen_d    = (gnt_q == GNT_M1) ? arlen1 : arlen2;
          beat_cnt_d = 8'd0;
          last_gnt_d = gnt_q;
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (r_hs) begin
          // Counter wraps naturally; only rlast_s ends the burst.
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (rlast_s) begin
            rd_state_d = R_IDLE;
            if (beat_cnt_q != arlen_q) begin
              burst_err_d = 1'b1;
            end
          end
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Read channel routing. Everything defaults to zero so that idle and reset
  // present quiet, all-zero outputs to both sides.
  // --------------------------------------------------------------------------
  always_comb begin
    araddr_s  = '0;
    arburst_s = 2'd0;
    arlen_s   = 8'd0;
    arsize_s  = 3'd0;
    arvalid_s = 1'b0;
    arready1  = 1'b0;
    arready2  = 1'b0;
    rdata1    = '0;
    rresp1    = 2'd0;
    rlast1    = 1'b0;
    rvalid1   = 1'b0;
    rdata2    = '0;
    rresp2    = 2'd0;
    rlast2    = 1'b0;
    rvalid2   = 1'b0;
    rready_s  = 1'b0;
    if (rd_state_q == R_AR) begin
      if (gnt_q == GNT_M1) begin
        araddr_s  = araddr1;
        arburst_s = arburst1;
        arlen_s   = arlen1;
        arsize_s  = arsize1;
        arvalid_s = arvalid1;
        arready1  = arready_s;
      end else begin
        araddr_s  = araddr2;
        arburst_s = arburst2;
        arlen_s   = arlen2;
        arsize_s  = arsize2;
        arvalid_s = arvalid2;
        arready2  = arready_s;
      end
    end
    if (rd_state_q == R_DATA) begin
      rready_s = gnt_rready;
      if (gnt_q == GNT_M1) begin
        rdata1  = rdata_s;
        rresp1  = rresp_s;
        rlast1  = rlast_s;
        rvalid1 = rvalid_s;
      end else begin
        rdata2  = rdata_s;
        rresp2  = rresp_s;
        rlast2  = rlast_s;
        rvalid2 = rvalid_s;
      end
    end
  end

  assign rd_busy   = (rd_state_q != R_IDLE);
  assign burst_err = burst_err_q;

  // --------------------------------------------------------------------------
  // Write FSM: single outstanding write from master 2
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q <= W_IDLE;
    end else begin
      wr_state_q <= wr_state_d;
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    case (wr_state_q)
      W_IDLE: if (awvalid2)                      wr_state_d = W_ADDR;
      W_ADDR: if (awvalid2 && awready_s)         wr_state_d = W_DATA;
      W_DATA: if (wvalid2 && wready_s && wlast2) wr_state_d = W_RESP;
      W_RESP: if (bvalid_s && bready2)           wr_state_d = W_IDLE;
      default:                                   wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    awaddr_s  = '0;
    awburst_s = 2'd0;
    awlen_s   = 8'd0;
    awvalid_s = 1'b0;
    awready2  = 1'b0;
    wdata_s   = '0;
    wstrb_s   = '0;
    wlast_s   = 1'b0;
    wvalid_s  = 1'b0;
    wready2   = 1'b0;
    bresp2    = 2'd0;
    bvalid2   = 1'b0;
    bready_s  = 1'b0;
    case (wr_state_q)
      W_ADDR: begin
        awaddr_s  = awaddr2;
        awburst_s = awburst2;
        awlen_s   = awlen2;
        awvalid_s = awvalid2;
        awready2  = awready_s;
      end
      W_DATA: begin
        wdata_s  = wdata2;
        wstrb_s  = wstrb2;
        wlast_s  = wlast2;
        wvalid_s = wvalid2;
        wready2  = wready_s;
      end
      W_RESP: begin
        bresp2   = bresp_s;
        bvalid2  = bvalid_s;
        bready_s = bready2;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_arbiter2
//  Purpose  : Self-checking bench for axi_arbiter2: directed scenarios for
//             reset, single read, contention order, burst error, write with
//             concurrent read and mid-burst reset, followed by a randomized
//             read phase checked against a transaction-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axi_arbiter2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] araddr1, araddr2, awaddr2, araddr_s, awaddr_s;
  logic [1:0]  arburst1, arburst2, awburst2, arburst_s, awburst_s;
  logic [7:0]  arlen1, arlen2, awlen2, arlen_s, awlen_s;
  logic [2:0]  arsize1, arsize2, arsize_s;
  logic        arvalid1, arready1, arvalid2, arready2, arvalid_s, arready_s;
  logic [63:0] rdata1, rdata2, rdata_s, wdata2, wdata_s;
  logic [1:0]  rresp1, rresp2, rresp_s, bresp2, bresp_s;
  logic        rlast1, rlast2, rlast_s;
  logic        rvalid1, rvalid2, rvalid_s, rready1, rready2, rready_s;
  logic        awvalid2, awready2, awvalid_s, awready_s;
  logic [7:0]  wstrb2, wstrb_s;
  logic        wlast2, wlast_s, wvalid2, wready2, wvalid_s, wready_s;
  logic        bvalid2, bready2, bvalid_s, bready_s;
  logic        rd_busy, burst_err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  axi_arbiter2 #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) dut (
    .clk(clk), .rst(rst),
    .araddr1(araddr1), .arburst1(arburst1), .arlen1(arlen1), .arsize1(arsize1),
    .arvalid1(arvalid1), .arready1(arready1),
    .rdata1(rdata1), .rresp1(rresp1), .rlast1(rlast1), .rvalid1(rvalid1), .rready1(rready1),
    .araddr2(araddr2), .arburst2(arburst2), .arlen2(arlen2), .arsize2(arsize2),
    .arvalid2(arvalid2), .arready2(arready2),
    .rdata2(rdata2), .rresp2(rresp2), .rlast2(rlast2), .rvalid2(rvalid2), .rready2(rready2),
    .awaddr2(awaddr2), .awburst2(awburst2), .awlen2(awlen2), .awvalid2(awvalid2), .awready2(awready2),
    .wdata2(wdata2), .wstrb2(wstrb2), .wlast2(wlast2), .wvalid2(wvalid2), .wready2(wready2),
    .bresp2(bresp2), .bvalid2(bvalid2), .bready2(bready2),
    .araddr_s(araddr_s), .arburst_s(arburst_s), .arlen_s(arlen_s), .arsize_s(arsize_s),
    .arvalid_s(arvalid_s), .arready_s(arready_s),
    .rdata_s(rdata_s), .rresp_s(rresp_s), .rlast_s(rlast_s), .rvalid_s(rvalid_s), .rready_s(rready_s),
    .awaddr_s(awaddr_s), .awburst_s(awburst_s), .awlen_s(awlen_s), .awvalid_s(awvalid_s), .awready_s(awready_s),
    .wdata_s(wdata_s), .wstrb_s(wstrb_s), .wlast_s(wlast_s), .wvalid_s(wvalid_s), .wready_s(wready_s),
    .bresp_s(bresp_s), .bvalid_s(bvalid_s), .bready_s(bready_s),
    .rd_busy(rd_busy), .burst_err(burst_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [63:0] exp_data(input logic [31:0] a, input int b);
    logic [7:0] bb;
    bb = b[7:0];
    return {a, ~a} ^ {56'd0, bb};
  endfunction

  task automatic idle_inputs();
    araddr1 = '0; arburst1 = '0; arlen1 = '0; arsize1 = '0; arvalid1 = 0; rready1 = 0;
    araddr2 = '0; arburst2 = '0; arlen2 = '0; arsize2 = '0; arvalid2 = 0; rready2 = 0;
    awaddr2 = '0; awburst2 = '0; awlen2 = '0; awvalid2 = 0;
    wdata2 = '0; wstrb2 = '0; wlast2 = 0; wvalid2 = 0; bready2 = 0;
    arready_s = 0; rdata_s = '0; rresp_s = '0; rlast_s = 0; rvalid_s = 0;
    awready_s = 0; wready_s = 0; bresp_s = '0; bvalid_s = 0;
  endtask

  // Enters and leaves one time unit after a rising edge.
  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Presents an AR request from master m and waits for the slave handshake.
  task automatic issue_ar(input int m, input logic [31:0] a, input logic [7:0] len);
    bit done;
    done = 0;
    if (m == 1) begin araddr1 = a; arlen1 = len; arsize1 = 3; arburst1 = 1; arvalid1 = 1; end
    else        begin araddr2 = a; arlen2 = len; arsize2 = 3; arburst2 = 1; arvalid2 = 1; end
    arready_s = 1;
    for (int i = 0; i < 10 && !done; i++) begin
      #1;
      if (arvalid_s && arready_s && ((m == 1) ? arready1 : arready2)) begin
        check("ar_addr", araddr_s, a);
        check("ar_len", arlen_s, len);
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (m == 1) arvalid1 = 0; else arvalid2 = 0;
    arready_s = 0;
    check("ar_done", done, 1);
  endtask

  // Slave returns nbeats beats (rlast on beat last_at); bp toggles rready.
  task automatic serve_read(input int m, input int nbeats, input int last_at, input bit bp,
                            input logic [63:0] base);
    int  beat;
    int  cyc;
    bit  rr;
    beat = 0;
    cyc  = 0;
    while (beat < nbeats && cyc < 40) begin
      rr = bp ? cyc[0] : 1'b1;
      rvalid_s = 1; rdata_s = base + 64'(beat); rresp_s = 0; rlast_s = (beat == last_at);
      if (m == 1) rready1 = rr; else rready2 = rr;
      #1;
      check("r_rready_s", rready_s, rr);
      if (m == 1) begin
        check("r_valid1", rvalid1, 1);
        check("r_data1", rdata1, base + 64'(beat));
        check("r_last1", rlast1, beat == last_at);
        check("r_other2", rvalid2, 0);
      end else begin
        check("r_valid2", rvalid2, 1);
        check("r_data2", rdata2, base + 64'(beat));
        check("r_last2", rlast2, beat == last_at);
        check("r_other1", rvalid1, 0);
      end
      if (rr) beat++;
      @(posedge clk); #1;
      cyc++;
    end
    rvalid_s = 0; rlast_s = 0; rready1 = 0; rready2 = 0;
    check("r_done", beat, nbeats);
  endtask

  // Random-phase model state
  int          m_st[1:2];     // 0 gap, 1 requesting, 2 receiving
  int          m_gap[1:2];
  int          m_start[1:2];
  logic [31:0] m_addr[1:2];
  logic [7:0]  m_len[1:2];
  bit          s_busy;
  int          s_m, s_beat;
  logic [31:0] s_addr;
  logic [7:0]  s_len;
  bit          hs_ar, hs_r, rr_sel;
  int          hs_m, last_served, last_hs_cyc, n_bursts;

  initial begin
    idle_inputs();
    // ---------------- reset values with busy-looking inputs ----------------
    arvalid1 = 1; arvalid2 = 1; araddr1 = 32'h8000_0000; rvalid_s = 1; rready1 = 1;
    rdata_s = 64'h1234; awvalid2 = 1; wvalid2 = 1; bvalid_s = 1; bready2 = 1;
    arready_s = 1; awready_s = 1; wready_s = 1;
    #3;
    check("rst_arvalid_s", arvalid_s, 0);
    check("rst_araddr_s", araddr_s, 0);
    check("rst_arready", {arready1, arready2}, 0);
    check("rst_rvalid", {rvalid1, rvalid2}, 0);
    check("rst_rdata1", rdata1, 0);
    check("rst_rready_s", rready_s, 0);
    check("rst_aw_w_b", {awvalid_s, awready2, wvalid_s, wready2, bvalid2, bready_s}, 0);
    check("rst_busy_err", {rd_busy, burst_err}, 0);
    do_reset();

    // ---------------- M1 alone ----------------
    araddr1 = 32'h8000_0000; arlen1 = 0; arsize1 = 3; arburst1 = 1; arvalid1 = 1; arready_s = 1;
    #1;
    check("t1_idle_arvalid_s", arvalid_s, 0);
    check("t1_idle_arready1", arready1, 0);
    @(posedge clk); #1;
    #1;
    check("t1_arvalid_s", arvalid_s, 1);
    check("t1_araddr_s", araddr_s, 32'h8000_0000);
    check("t1_arready", {arready1, arready2}, 2'b10);
    check("t1_busy", rd_busy, 1);
    @(posedge clk); #1;
    arvalid1 = 0; arready_s = 0;
    rvalid_s = 1; rdata_s = 64'h1122334455667788; rlast_s = 1; rready1 = 1;
    #1;
    check("t1_rvalid1", rvalid1, 1);
    check("t1_rdata1", rdata1, 64'h1122334455667788);
    check("t1_rvalid2", rvalid2, 0);
    @(posedge clk); #1;
    rvalid_s = 0; rlast_s = 0; rready1 = 0;
    #1;
    check("t1_busy_done", rd_busy, 0);
    check("t1_err", burst_err, 0);
    @(posedge clk); #1;

    // ---------------- contention right after reset ----------------
    do_reset();
    araddr1 = 32'h8000_0100; arlen1 = 0; arsize1 = 3; arburst1 = 1; arvalid1 = 1;
    araddr2 = 32'ha000_0048; arlen2 = 0; arsize2 = 3; arburst2 = 1; arvalid2 = 1;
    arready_s = 1;
    #1;
    check("t2_idle_ready", {arready1, arready2, arvalid_s}, 0);
    @(posedge clk); #1;
    #1;
    check("t2_first_addr", araddr_s, 32'ha000_0048);
    check("t2_first_rdy", {arready1, arready2}, 2'b01);
    @(posedge clk); #1;
    arvalid2 = 0;
    #1;
    check("t2_m1_blocked", {arready1, arvalid_s}, 0);
    serve_read(2, 1, 0, 0, 64'hA0A0_0000_0000_0000);
    issue_ar(1, 32'h8000_0100, 0);
    serve_read(1, 1, 0, 0, 64'h8080_0000_0000_0000);

    // ---------------- bursts and burst_err ----------------
    issue_ar(1, 32'h8000_0300, 3);
    serve_read(1, 4, 3, 1, 64'h3000);
    #1 check("t3_no_err", burst_err, 0);
    @(posedge clk); #1;
    issue_ar(1, 32'h8000_0400, 3);
    serve_read(1, 3, 2, 0, 64'h4000);
    #1 check("t3_err_set", burst_err, 1);
    @(posedge clk); #1;
    issue_ar(1, 32'h8000_0500, 0);
    serve_read(1, 1, 0, 0, 64'h5000);
    #1 check("t3_err_sticky", burst_err, 1);
    check("t3_idle", rd_busy, 0);
    @(posedge clk); #1;

    // ---------------- M2 write with concurrent M1 read ----------------
    do_reset();
    #1 check("t4_err_cleared", burst_err, 0);
    awaddr2 = 32'h8000_1000; awlen2 = 0; awburst2 = 1; awvalid2 = 1; awready_s = 1;
    wdata2 = 64'hdeadbeef; wstrb2 = 8'h0f; wlast2 = 1; wvalid2 = 1; wready_s = 1;
    araddr1 = 32'h8000_0600; arlen1 = 0; arsize1 = 3; arburst1 = 1; arvalid1 = 1; arready_s = 1;
    #1;
    check("t4_idle_aw", {awvalid_s, awready2, wready2}, 0);
    @(posedge clk); #1;
    #1;
    check("t4_awvalid_s", awvalid_s, 1);
    check("t4_awaddr_s", awaddr_s, 32'h8000_1000);
    check("t4_awready2", awready2, 1);
    check("t4_w_gated", {wvalid_s, wready2}, 0);
    check("t4_ar_concurrent", araddr_s, 32'h8000_0600);
    @(posedge clk); #1;
    awvalid2 = 0; arvalid1 = 0;
    rvalid_s = 1; rdata_s = 64'h0606; rlast_s = 1; rready1 = 1;
    #1;
    check("t4_wvalid_s", wvalid_s, 1);
    check("t4_wdata_s", wdata_s, 64'hdeadbeef);
    check("t4_wstrb_s", wstrb_s, 8'h0f);
    check("t4_wready2", wready2, 1);
    check("t4_aw_gone", awvalid_s, 0);
    check("t4_rdata1", rdata1, 64'h0606);
    @(posedge clk); #1;
    wvalid2 = 0; rvalid_s = 0; rlast_s = 0; rready1 = 0;
    bvalid_s = 1; bresp_s = 0; bready2 = 1;
    #1;
    check("t4_bvalid2", bvalid2, 1);
    check("t4_bresp2", bresp2, 0);
    check("t4_bready_s", bready_s, 1);
    check("t4_w_done", {wvalid_s, wready2}, 0);
    check("t4_read_done", rd_busy, 0);
    @(posedge clk); #1;
    bresp_s = 2'b10;
    #1;
    check("t4_bvalid2_once", bvalid2, 0);
    check("t4_bready_s_off", bready_s, 0);
    check("t4_bresp2_zero", bresp2, 0);
    @(posedge clk); #1;
    idle_inputs();

    // ---------------- reset during data phase ----------------
    issue_ar(1, 32'h8000_0700, 3);
    serve_read(1, 1, 3, 0, 64'h7000);
    rvalid_s = 1; rdata_s = 64'h7001; rready1 = 1;
    #1;
    check("t5_pre_rvalid1", rvalid1, 1);
    #1 rst = 1'b1;
    #1;
    check("t5_rst_rvalid1", rvalid1, 0);
    check("t5_rst_rdata1", rdata1, 0);
    check("t5_rst_rready_s", rready_s, 0);
    check("t5_rst_busy", rd_busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("t5_post_rvalid1", rvalid1, 0);
    @(posedge clk); #1;
    check("t5_post_busy", rd_busy, 0);
    rvalid_s = 0; rready1 = 0;
    issue_ar(1, 32'h8000_0800, 1);
    serve_read(1, 2, 1, 0, 64'h8000);
    #1 check("t5_clean", burst_err, 0);
    @(posedge clk); #1;

    // ---------------- randomized reads from both masters ----------------
    do_reset();
    for (int m = 1; m <= 2; m++) begin
      m_st[m] = 0; m_gap[m] = $urandom_range(0, 2); m_start[m] = 0;
      m_addr[m] = '0; m_len[m] = '0;
    end
    s_busy = 0; s_m = 1; s_beat = 0; s_addr = '0; s_len = '0;
    hs_ar = 0; hs_r = 0; hs_m = 1;
    last_served = 1; last_hs_cyc = -1; n_bursts = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (hs_ar) begin
        m_st[hs_m] = 2;
        s_busy = 1; s_m = hs_m; s_addr = m_addr[hs_m]; s_len = m_len[hs_m]; s_beat = 0;
      end
      if (hs_r) begin
        s_beat++;
        if (s_beat > int'(s_len)) begin
          s_busy = 0; m_st[s_m] = 0; m_gap[s_m] = $urandom_range(0, 3); n_bursts++;
        end
      end
      for (int m = 1; m <= 2; m++) begin
        if (m_st[m] == 0) begin
          if (m_gap[m] == 0) begin
            m_st[m] = 1; m_start[m] = cyc;
            m_addr[m] = ((m == 1) ? 32'h8000_0000 : 32'ha000_0000) | ($urandom & 32'h0fff_fff8);
            m_len[m] = 8'($urandom_range(0, 3));
          end else begin
            m_gap[m]--;
          end
        end
      end
      arvalid1 = (m_st[1] == 1); araddr1 = m_addr[1]; arlen1 = m_len[1]; arsize1 = 3; arburst1 = 1;
      arvalid2 = (m_st[2] == 1); araddr2 = m_addr[2]; arlen2 = m_len[2]; arsize2 = 3; arburst2 = 2;
      rready1 = 1'($urandom_range(0, 1));
      rready2 = 1'($urandom_range(0, 1));
      arready_s = 1'($urandom_range(0, 1));
      rvalid_s = s_busy && ($urandom_range(0, 3) != 0);
      rdata_s = exp_data(s_addr, s_beat);
      rlast_s = s_busy && (s_beat == int'(s_len));
      rresp_s = 2'($urandom_range(0, 3));
      #1;
      hs_ar = 0; hs_r = 0;
      if (arvalid_s && arready_s) begin
        hs_m = (araddr_s[31:28] == 4'h8) ? 1 : 2;
        hs_ar = 1;
        check("rnd_ar_pending", m_st[hs_m], 1);
        check("rnd_ar_addr", araddr_s, m_addr[hs_m]);
        check("rnd_ar_len", arlen_s, m_len[hs_m]);
        check("rnd_ar_burst", arburst_s, (hs_m == 1) ? 1 : 2);
        check("rnd_ar_rdy", {arready1, arready2}, (hs_m == 1) ? 2'b10 : 2'b01);
        if (m_st[3 - hs_m] == 1 && m_start[3 - hs_m] <= last_hs_cyc)
          check("rnd_rr_order", hs_m, 3 - last_served);
        last_served = hs_m; last_hs_cyc = cyc;
      end
      if (s_busy) begin
        rr_sel = (s_m == 1) ? rready1 : rready2;
        check("rnd_busy", rd_busy, 1);
        check("rnd_rready_s", rready_s, rr_sel);
        check("rnd_rvalid", {rvalid1, rvalid2}, (s_m == 1) ? {rvalid_s, 1'b0} : {1'b0, rvalid_s});
        if (rvalid_s) begin
          check("rnd_rdata", (s_m == 1) ? rdata1 : rdata2, exp_data(s_addr, s_beat));
          check("rnd_rlast", (s_m == 1) ? rlast1 : rlast2, s_beat == int'(s_len));
          check("rnd_rresp", (s_m == 1) ? rresp1 : rresp2, rresp_s);
        end
        hs_r = rvalid_s && rr_sel;
      end else begin
        check("rnd_rvalid_idle", {rvalid1, rvalid2, rready_s}, 0);
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    check("rnd_bursts", n_bursts > 50, 1);
    check("rnd_burst_err", burst_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_arbiter2.md
Name: axi_arbiter2

Overview:
- Two-master to one-slave AXI arbiter placed directly downstream of the LSU memory stage and of the instruction-fetch stage.
- Master 1 (IFU) is read-only. Master 2 (LSU bus port: dcache and uncached device path) reads and writes.
- Presents a single AXI master to the memory/device interconnect, with independent read and write arbitration FSMs.

Parameters:
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 64, AXI data width; strobe width is DATA_WIDTH/8

Ports:
- clk  input  1  system clock
- rst  input  1  reset
- araddr1/arburst1/arlen1/arsize1  input  32/2/8/3  M1 AR payload
- arvalid1  input  1  M1 AR valid
- arready1  output  1  M1 AR ready
- rdata1/rresp1/rlast1  output  64/2/1  M1 R payload
- rvalid1  output  1  M1 R valid
- rready1  input  1  M1 R ready
- araddr2/arburst2/arlen2/arsize2  input  32/2/8/3  M2 AR payload
- arvalid2  input  1  M2 AR valid
- arready2  output  1  M2 AR ready
- rdata2/rresp2/rlast2  output  64/2/1  M2 R payload
- rvalid2  output  1  M2 R valid
- rready2  input  1  M2 R ready
- awaddr2/awburst2/awlen2  input  32/2/8  M2 AW payload
- awvalid2  input  1  M2 AW valid
- awready2  output  1  M2 AW ready
- wdata2/wstrb2/wlast2  input  64/8/1  M2 W payload
- wvalid2  input  1  M2 W valid
- wready2  output  1  M2 W ready
- bresp2  output  2  M2 B response
- bvalid2  output  1  M2 B valid
- bready2  input  1  M2 B ready
- araddr_s/arburst_s/arlen_s/arsize_s/arvalid_s  output  32/2/8/3/1  slave AR
- arready_s  input  1  slave AR ready
- rdata_s/rresp_s/rlast_s/rvalid_s  input  64/2/1/1  slave R
- rready_s  output  1  slave R ready
- awaddr_s/awburst_s/awlen_s/awvalid_s  output  32/2/8/1  slave AW
- awready_s  input  1  slave AW ready
- wdata_s/wstrb_s/wlast_s/wvalid_s  output  64/8/1/1  slave W
- wready_s  input  1  slave W ready
- bresp_s/bvalid_s  input  2/1  slave B
- bready_s  output  1  slave B ready
- rd_busy  output  1  read FSM not idle
- burst_err  output  1  sticky: rlast_s seen on a beat other than beat arlen

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous, active-high. All state resets to idle, gnt=M2, last_gnt=M1, beat counter=0, burst_err=0.
- Reset values: every valid/ready output is 0 during reset; payload outputs are 0.
- Read FSM states: R_IDLE, R_AR, R_DATA. Registers: gnt (1 bit), latched arlen, 8-bit beat counter.
- R_IDLE:
  - Only arvalid1 pending: gnt=M1.
  - Only arvalid2 pending: gnt=M2.
  - Both pending: grant the master not in last_gnt (round-robin).
  - On any grant, go to R_AR next cycle. Arbitration adds 1 cycle of latency. No ready is asserted in R_IDLE.
- R_AR:
  - Slave AR = granted master's AR.
  - arvalid_s = granted arvalid. arready of the granted master = arready_s; the other master's arready = 0.
  - On handshake: latch arlen, clear beat counter, update last_gnt, go to R_DATA.
  - If the granted master drops arvalid before handshake (protocol violation): return to R_IDLE.
- R_DATA:
  - rvalid_s/rdata_s/rresp_s/rlast_s are routed to the granted master. The other master sees rvalid=0 and zero payload.
  - rready_s = granted master's rready.
  - Each R beat handshake increments the beat counter.
  - Handshake with rlast_s=1: go to R_IDLE. If beat counter != latched arlen at that beat, set burst_err.
  - Counter wraps at 255. Only rlast_s terminates the burst.
- rd_busy = (state != R_IDLE).
- Write FSM states: W_IDLE, W_ADDR, W_DATA, W_RESP. Single write outstanding; M2 is the only writer.
  - W_IDLE: awvalid2 -> W_ADDR next cycle.
  - W_ADDR: forward AW; on awready_s handshake -> W_DATA.
  - W_DATA: forward W, wready2 = wready_s; on handshake with wlast2 -> W_RESP.
  - W_RESP: forward B, bready_s = bready2; on handshake -> W_IDLE.
  - In all other states the corresponding valid/ready outputs are 0.
- Read and write FSMs are fully independent. A simultaneous M2 read and M2 write both proceed.
- Reset mid-burst: FSMs return to idle immediately. No partial beat is forwarded after reset deasserts.

Test Plan:
- M1 alone: araddr1=0x80000000, arlen1=0, slave returns rdata 0x1122334455667788 with rlast -> arvalid_s in cycle 2, rdata1 matches, rvalid2 stays 0, rd_busy drops after the rlast beat.
- Both masters assert arvalid in the same cycle after reset (last_gnt=M1) -> M2 served first (araddr2=0xa0000048), then M1. Order is M2, M1.
- Burst: M1 arlen=3 with 4 beats, slave rready_s backpressure toggling via rready1 -> 4 beats delivered in order, burst_err=0. Repeat with rlast on beat 2 -> burst_err=1 and sticky.
- M2 write awaddr=0x80001000, wstrb=0x0f, wdata=0xdeadbeef, slave bresp=0 -> AW, W, B sequenced; bvalid2 pulses once; concurrent M1 read completes undisturbed.
- rst asserted while in R_DATA after 1 of 4 beats -> all outputs 0 asynchronously; after release, new M1 request served from R_IDLE normally.
